// File: rtl/switch_arb_pkg.sv
// Shared types and defaults for the switch request/grant arbiter clients.
package switch_arb_pkg;
  localparam int DATA_W_DEF    = 8;
  localparam int DEPTH_DEF     = 8;
  localparam int BURST_LEN_DEF = 4;
  localparam int NUM_PORTS     = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RELEASE
  } req_state_e;
endpackage

// File: rtl/port_req_fifo.sv
// Beat buffer for one requester port.
// Full is judged on the pre-pop count.
module port_req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign push      = wr_en_i & ~full_o;
  assign pop       = rd_en_i & (count_q != '0);
  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push)
      wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)
      rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/switch_port_requester.sv
// Requester client: buffers beats, requests once a full packet is held,
// streams on grant and drops the request for one cycle between packets.
module switch_port_requester
  import switch_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_Wr_En,
  input  logic [DATA_W-1:0] i_Wr_Data,
  output logic              o_Full,
  output logic              o_Overflow,
  output logic              o_Req,
  input  logic              i_Gnt,
  output logic              o_Valid,
  output logic [DATA_W-1:0] o_Data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  req_state_e    state_q;
  logic [BW-1:0] beat_q;
  logic          ovf_q;
  logic [CW-1:0] count;
  logic          full;
  logic          beat;

  // Grant is only honoured while requesting; a stale grant in RELEASE is dropped.
  assign beat       = (state_q == ACTIVE) & i_Gnt;
  assign o_Valid    = beat;
  assign o_Req      = (state_q == ACTIVE);
  assign o_Full     = full;
  assign o_Overflow = ovf_q;

  port_req_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (i_Wr_En),
    .wr_data_i (i_Wr_Data),
    .rd_en_i   (beat),
    .rd_data_o (o_Data),
    .count_o   (count),
    .full_o    (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= i_Wr_En & full;
      unique case (state_q)
        IDLE: begin
          if (count >= CW'(BURST_LEN))
            state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (i_Gnt) begin
            if (beat_q == BW'(BURST_LEN - 1)) begin
              state_q <= RELEASE;
              beat_q  <= '0;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/switch_port_requester.md
Name: switch_port_requester

Overview:
- Requester-side client for the switch's fixed-priority request/grant arbiter. It sits on one input port in front of the arbiter.
- Buffers write beats in a small FIFO and raises o_Req once a full packet (BURST_LEN beats) is buffered.
- Streams one beat per granted cycle, stalling whenever a higher-priority port steals the grant.
- Drops o_Req for one cycle after each packet so the arbiter can re-evaluate.

Parameters:
DATA_W, 8, beat width in bits
DEPTH, 8, FIFO depth in beats (power of 2, >= BURST_LEN)
BURST_LEN, 4, beats per packet (>= 1, <= DEPTH)

Ports:
clk  input  1  clock; one clock; reset is synchronous and active-high
reset  input  1  synchronous active-high reset
i_Wr_En  input  1  write one beat into FIFO
i_Wr_Data  input  DATA_W  beat to write
o_Full  output  1  FIFO full (count == DEPTH)
o_Overflow  output  1  registered 1-cycle pulse: write attempted while full
o_Req  output  1  request line to arbiter (one bit of its request vector)
i_Gnt  input  1  this port's grant bit from arbiter (registered by arbiter, 1-cycle req->gnt)
o_Valid  output  1  beat transferred this cycle
o_Data  output  DATA_W  FIFO head; meaningful only when o_Valid=1

Behaviour:
- Reset (sync, takes priority over all else):
  - FIFO pointers and count = 0; state = IDLE; beat counter = 0.
  - o_Req=0, o_Valid=0, o_Full=0, o_Overflow=0.
  - Reset asserted mid-burst aborts the packet; remaining beats are discarded.
- FIFO:
  - A write is accepted when i_Wr_En=1 and count < DEPTH.
  - o_Full is evaluated on the pre-pop count: a write in the same cycle as a pop while full is dropped and pulses o_Overflow the next cycle.
  - Pointers wrap modulo DEPTH. Count updates at the clock edge after the write or pop.
  - Simultaneous accepted write and pop leaves count unchanged.
- State machine (registered state; o_Req decoded from state, no combinational path from i_Gnt to o_Req):
  - IDLE: o_Req=0. Transition to ACTIVE when count >= BURST_LEN.
  - ACTIVE: o_Req=1.
    - A beat occurs when i_Gnt=1: o_Valid=1 combinationally, o_Data = FIFO head, head pops, beat counter increments.
    - When i_Gnt=0, the block stalls: no pop, counter holds, o_Req stays 1.
    - On the beat where counter == BURST_LEN-1, go to RELEASE and clear the counter.
  - RELEASE: o_Req=0 for exactly one cycle.
    - i_Gnt is ignored here (the arbiter's stale grant from the last request cycle): o_Valid=0, no pop.
    - Transition to IDLE.
- o_Valid = (state==ACTIVE) & i_Gnt. The FIFO is never empty in ACTIVE because a full packet is guaranteed on entry.
- Timing for a packet written on cycles 0..3 with an idle arbiter:
  - count=4 at cycle 4; ACTIVE (o_Req=1) at cycle 5.
  - Grant at cycle 6; beats on cycles 6-9.
  - RELEASE at cycle 10; IDLE at cycle 11; next packet's o_Req no earlier than cycle 12.
- Writes continue to be accepted in every state.

Decomposition:
- Package switch_arb_pkg holds:
  - state enum (IDLE, ACTIVE, RELEASE)
  - default DATA_W/DEPTH/BURST_LEN constants
  - NUM_PORTS=4
- One natural sub-module, port_req_fifo: a synchronous FIFO (wr_en/wr_data/rd_en/rd_data/count/full) instantiated once.
- The FSM, beat counter and overflow flag live in the top level.

Test Plan:
- Reset: drive reset=1 mid-burst with i_Gnt=1 -> next cycle o_Req=0, o_Valid=0, count=0; with reset released and no writes, o_Req stays 0.
- Single packet, constant grant: write 0xA0..0xA3 on cycles 0-3; tie i_Gnt to o_Req delayed 1 cycle -> o_Req high cycles 5-9; o_Valid on cycles 6-9 with data A0,A1,A2,A3; o_Req=0 on cycle 10 with no beat despite i_Gnt=1.
- Grant stolen mid-burst: same packet, force i_Gnt=0 on cycles 7-8 -> beats A0 at 6, A1 at 9, A2 at 10, A3 at 11; o_Req held high throughout.
- Partial packet: write 3 beats -> o_Req stays 0 indefinitely; write 4th beat -> o_Req rises 2 cycles after that write.
- Overflow/wrap: DEPTH=8 with i_Gnt=0; write 9 beats -> o_Full=1 after the 8th write; o_Overflow pulses once on the 9th write; then grant 2 packets -> 8 beats out in order, pointers wrap, count=0.
- Back-to-back: 8 beats buffered, permanent grant -> packet 1 beats cycles t..t+3, RELEASE t+4, IDLE t+5, o_Req t+6, packet 2 beats t+7..t+10.
